// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or_red_pipe_if.sv
// Handshake bundle for the pipelined OR reduction.
// Producer/consumer side uses the master modport, the reduction block the
// slave modport. The sticky-hit signals exist only when OR_PIPE_STICKY_EN
// is defined.
interface gf180mcu_fd_sc_mcu7t5v0__or_red_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] A;
  logic             IN_VALID;
  logic             IN_READY;
  logic             Z;
  logic [IDXW-1:0]  IDX;
  logic             OUT_VALID;
  logic             OUT_READY;
`ifdef OR_PIPE_STICKY_EN
  logic             CLR;
  logic             STICKY_Z;
  logic [IDXW-1:0]  STICKY_IDX;

  modport master (
    output A, IN_VALID, OUT_READY, CLR,
    input  IN_READY, Z, IDX, OUT_VALID, STICKY_Z, STICKY_IDX
  );

  modport slave (
    input  A, IN_VALID, OUT_READY, CLR,
    output IN_READY, Z, IDX, OUT_VALID, STICKY_Z, STICKY_IDX
  );
`else
  modport master (
    output A, IN_VALID, OUT_READY,
    input  IN_READY, Z, IDX, OUT_VALID
  );

  modport slave (
    input  A, IN_VALID, OUT_READY,
    output IN_READY, Z, IDX, OUT_VALID
  );
`endif
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or_red_pipe.sv
// Pipelined wide OR reduction with lowest-set-bit index.
// Each non-final slot folds its input nodes by four (group OR plus the
// lowest index of the group); the final slot priority-selects across the
// remaining nodes, so Z and IDX always come straight from flops.
// Optional feature: define OR_PIPE_STICKY_EN to add the sticky hit
// accumulator (CLR, STICKY_Z, STICKY_IDX).
module gf180mcu_fd_sc_mcu7t5v0__or_red_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu7t5v0__or_red_pipe_if.slave bus
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Number of reduction nodes held by slot k (0-based). Every slot but the
  // last divides the node count by four; the last collapses it to one.
  function automatic int slot_nodes(input int k);
    int n;
    n = WIDTH;
    for (int i = 0; i <= k; i++) begin
      n = (i == STAGES - 1) ? 1 : (n + 3) / 4;
    end
    return n;
  endfunction

  // Supplies carry no logic function.
  wire unused_supply = VDD ^ VSS;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] up_valid;

  // Valid bit arriving at each slot: the input for slot 0, else the slot before.
  assign up_valid = STAGES'({valid_q, bus.IN_VALID});

  // Slot k may load when it or any slot downstream of it is empty, or the
  // consumer takes the head this cycle: that is exactly "k+1 is empty or
  // advancing" unrolled down the chain.
  always_comb begin : p_handshake
    logic room;
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    load    = '0;
    room    = bus.OUT_READY;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room    = room | ~valid_q[k];
      load[k] = room;
    end
    valid_d = (load & up_valid) | (~load & valid_q);
  end

  // Slot valid bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else begin
      // NOTE: state uses <= so each slot samples its neighbour's pre-edge value.
      valid_q <= valid_d;
    end
  end

  assign bus.IN_READY  = load[0];
  assign bus.OUT_VALID = valid_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : gen_slot
    localparam bit LAST  = (k == STAGES - 1);
    localparam int N_IN  = (k == 0) ? WIDTH : slot_nodes(k - 1);
    localparam int N_OUT = slot_nodes(k);
    // Non-final slots see their input padded to a whole number of quads.
    localparam int N_SRC = LAST ? N_IN : 4 * N_OUT;

    logic [N_SRC-1:0]           src_hit;
    logic [N_SRC-1:0][IDXW-1:0] src_idx;
    logic [N_OUT-1:0]           hit_d;
    logic [N_OUT-1:0]           hit_q;
    logic [N_OUT-1:0][IDXW-1:0] idx_d;
    logic [N_OUT-1:0][IDXW-1:0] idx_q;

    if (k == 0) begin : g_src_in
      // Slot 0 sees the raw vector; each bit is a node whose index is its position.
      always_comb begin
        src_hit             = '0;
        src_idx             = '0;
        src_hit[WIDTH-1:0]  = bus.A;
        for (int i = 0; i < WIDTH; i++) begin
          src_idx[i] = IDXW'(i);
        end
      end
    end else begin : g_src_prev
      // Later slots see the registered nodes of the slot before.
      always_comb begin
        src_hit            = '0;
        src_idx            = '0;
        src_hit[N_IN-1:0]  = gen_slot[k-1].hit_q;
        src_idx[N_IN-1:0]  = gen_slot[k-1].idx_q;
      end
    end

    if (LAST) begin : g_final
      // Final fold: the lowest hitting node wins; no hit leaves IDX at 0.
      always_comb begin
        hit_d = '0;
        idx_d = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
          if (src_hit[i]) begin
            hit_d[0] = 1'b1;
            idx_d[0] = src_idx[i];
          end
        end
      end
    end else begin : g_quad
      // Radix-4 fold: group OR plus the index of the lowest hit in the group.
      always_comb begin
        hit_d = '0;
        idx_d = '0;
        for (int g = 0; g < N_OUT; g++) begin
          for (int j = 3; j >= 0; j--) begin
            if (src_hit[4*g+j]) begin
              hit_d[g] = 1'b1;
              idx_d[g] = src_idx[4*g+j];
            end
          end
        end
      end
    end

    // Slot payload: loads only when a valid item enters, otherwise holds.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        // NOTE: payloads are reset as well so Z and IDX read 0 out of reset, not X.
        hit_q <= '0;
        idx_q <= '0;
      end else if (load[k] && up_valid[k]) begin
        hit_q <= hit_d;
        idx_q <= idx_d;
      end
    end
  end

  assign bus.Z   = gen_slot[STAGES-1].hit_q[0];
  assign bus.IDX = gen_slot[STAGES-1].idx_q[0];

`ifdef OR_PIPE_STICKY_EN
  logic            out_xfer;
  logic            sticky_z_q;
  logic            sticky_z_d;
  logic [IDXW-1:0] sticky_idx_q;
  logic [IDXW-1:0] sticky_idx_d;

  assign out_xfer = valid_q[STAGES-1] & bus.OUT_READY;

  // Sticky next state: a delivered hit sets (and beats CLR); the index is
  // captured only for the first hit since the last clear.
  always_comb begin
    sticky_z_d   = sticky_z_q;
    sticky_idx_d = sticky_idx_q;
    if (out_xfer && bus.Z) begin
      sticky_z_d = 1'b1;
      if (!sticky_z_q || bus.CLR) begin
        sticky_idx_d = bus.IDX;
      end
    end else if (bus.CLR) begin
      sticky_z_d   = 1'b0;
      sticky_idx_d = '0;
    end
  end

  // Sticky registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sticky_z_q   <= 1'b0;
      sticky_idx_q <= '0;
    end else begin
      sticky_z_q   <= sticky_z_d;
      sticky_idx_q <= sticky_idx_d;
    end
  end

  assign bus.STICKY_Z   = sticky_z_q;
  assign bus.STICKY_IDX = sticky_idx_q;
`endif

endmodule
